id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Registered, parametrised MIPS instruction-decode stage with valid/ready handshake.
- Sits between the IF pipeline register and EX.
- Decodes the instruction, drives register-file read ports, forms operand_1/operand_2, write-back target and FUNCT.
- Detects load-use hazards, stalls upstream, inserts bubbles, and honours pipeline flush.

Parameters:
- DATA_W, 32, operand/register data width
- ADDR_W, 32, instruction address width
- REG_AW, 5, register index width
- LINK_OFS, 8, byte offset added to addr for link address

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- flush  in  1  discard held and incoming instruction
- in_valid  in  1  IF holds valid instruction
- in_ready  out  1  ID accepts instruction this cycle
- in_addr  in  ADDR_W  instruction address
- in_inst  in  32  instruction word
- reg_read_en_1 / reg_read_en_2  out  1  regfile read enables (combinational from in_inst)
- reg_addr_1 / reg_addr_2  out  REG_AW  regfile read indices
- reg_data_1 / reg_data_2  in  DATA_W  regfile read data, same cycle
- ex_load  in  1  instruction in EX is a load
- ex_dst  in  REG_AW  destination of instruction in EX
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EX accepts bundle
- out_write_reg_en  out  1  write-back enable
- out_write_reg_addr  out  REG_AW  write-back index
- out_funct  out  FUNCT width  unified FUNCT code
- out_shamt  out  5  shift amount
- out_operand_1 / out_operand_2  out  DATA_W  operands
- out_store_data  out  DATA_W  rt data for SB/SH/SW
- out_illegal  out  1  unrecognised opcode/REGIMM rt

Behaviour:
- Reset (rst==0 at posedge): out_valid=0; all out_* data = 0. Read enables/addrs = 0 while rst==0.
- Read ports follow the operand-source rules for SPECIAL, imm-ALU, loads/stores, branches, REGIMM, CP0 and J/JAL/LUI. Unknown opcode: no reads, out_illegal=1.
- Operands:
  - operand_1 = link (addr+LINK_OFS) for JAL, JALR, BLTZAL, BGEZAL; reg_data_1 for imm/mem/SPECIAL; else 0.
  - operand_2 = zero-extended imm for ANDI/ORI/XORI; imm<<16 for LUI; sign-extended imm for ADDI/ADDIU/SLTI/SLTIU/loads/stores; reg_data_2 for SPECIAL; else 0.
  - Extension arithmetic is in DATA_W; sign fill uses imm[15].
- Write-back target:
  - rd for SPECIAL except JR.
  - rt for imm-ALU, LUI and loads.
  - 31 for JAL, BLTZAL, BGEZAL.
  - Otherwise no write.
  - write_reg_en forced 0 when the target is 0.
- Load-use hazard: stall = in_valid & ex_load & ex_dst!=0 & ((reg_read_en_1 & reg_addr_1==ex_dst) | (reg_read_en_2 & reg_addr_2==ex_dst)).
- Handshake:
  - in_ready = flush | (!stall & (!out_valid | out_ready)).
  - Transfer when in_valid & in_ready & !flush: bundle registered, out_valid=1 next cycle. Latency 1 cycle.
  - When out_ready & !transfer, out_valid<=0. A stall therefore produces one bubble per cycle.
  - !out_ready holds all out_* stable.
- Flush: highest priority after reset. out_valid<=0; the incoming instruction is consumed and discarded.
- Simultaneous flush and stall: flush wins.
- Reset mid-stall clears everything; no bundle survives.

Optional Feature:
- ID_BYPASS_EN defined adds ports wb_en (1), wb_addr (REG_AW) and wb_data (DATA_W).
- Any read with addr!=0 matching wb_addr while wb_en is set uses wb_data for operands/store_data in the same cycle.
- Undefined: no such ports; reg_data_* are used directly. The regfile is responsible for write-through.

Decomposition:
- Shared package/header holds opcode, REGIMM and funct codes, segment positions, bus widths and LINK_REG=31. The existing opcode.v/regimm.v/funct.v/segpos.v are extended, not duplicated.
- One sub-module: id_decode_comb, the pure combinational decode (read ports, operands, target, illegal).
- The existing FunctGen is instantiated inside id_decode_comb.
- id_stage_pipe adds the hazard logic, handshake and output register.

Test Plan:
- ORI $2,$1,0x8001 with reg_data_1=0x0000_00F0, out_ready=1 -> next cycle out_valid=1, op1=0xF0, op2=0x0000_8001, dst=2, en=1.
- ADDI $3,$1,-4 -> op2=0xFFFF_FFFC. LUI $4,0x1234 -> op2=0x1234_0000, no reads.
- JAL at addr 0x400 -> op1=0x408, dst=31, en=1. SPECIAL ADD $0,$1,$2 -> en=0.
- ex_load=1, ex_dst=5 with ADD $6,$5,$7 -> in_ready=0; bubble (out_valid=0) each cycle. Drop ex_load -> accepted next cycle.
- out_ready=0 for 3 cycles with a valid bundle -> outputs stable, in_ready=0. flush=1 -> out_valid=0 next cycle, in_ready=1.
- ID_BYPASS_EN defined, wb_en=1, wb_addr=1, wb_data=0xDEAD_BEEF, ADDU $2,$1,$0 -> op1=0xDEAD_BEEF. Same with wb_addr=0 -> regfile data is used.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// Shared MIPS decode definitions: opcodes, REGIMM/funct codes, field positions, widths.
// Optional write-back bypass into the decode stage is enabled with ID_BYPASS_EN.
package id_stage_pipe_pkg;

  localparam int unsigned INST_W    = 32;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned SHAMT_W   = 5;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned SEG_REG_W = 5;

  localparam int unsigned POS_OP    = 26;
  localparam int unsigned POS_RS    = 21;
  localparam int unsigned POS_RT    = 16;
  localparam int unsigned POS_RD    = 11;
  localparam int unsigned POS_SHAMT = 6;
  localparam int unsigned POS_FUNCT = 0;
  localparam int unsigned POS_IMM   = 0;

  localparam int unsigned LINK_REG  = 31;

  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM  = 6'h01;
  localparam logic [OP_W-1:0] OP_J       = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE     = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ    = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ    = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI    = 6'h08;
  localparam logic [OP_W-1:0] OP_ADDIU   = 6'h09;
  localparam logic [OP_W-1:0] OP_SLTI    = 6'h0A;
  localparam logic [OP_W-1:0] OP_SLTIU   = 6'h0B;
  localparam logic [OP_W-1:0] OP_ANDI    = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI     = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI    = 6'h0E;
  localparam logic [OP_W-1:0] OP_LUI     = 6'h0F;
  localparam logic [OP_W-1:0] OP_CP0     = 6'h10;
  localparam logic [OP_W-1:0] OP_LB      = 6'h20;
  localparam logic [OP_W-1:0] OP_LH      = 6'h21;
  localparam logic [OP_W-1:0] OP_LW      = 6'h23;
  localparam logic [OP_W-1:0] OP_LBU     = 6'h24;
  localparam logic [OP_W-1:0] OP_LHU     = 6'h25;
  localparam logic [OP_W-1:0] OP_SB      = 6'h28;
  localparam logic [OP_W-1:0] OP_SH      = 6'h29;
  localparam logic [OP_W-1:0] OP_SW      = 6'h2B;

  localparam logic [SEG_REG_W-1:0] RI_BLTZ   = 5'h00;
  localparam logic [SEG_REG_W-1:0] RI_BGEZ   = 5'h01;
  localparam logic [SEG_REG_W-1:0] RI_BLTZAL = 5'h10;
  localparam logic [SEG_REG_W-1:0] RI_BGEZAL = 5'h11;

  localparam logic [SEG_REG_W-1:0] CP0_MT = 5'h04;

  localparam logic [FUNCT_W-1:0] FN_SLL  = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL  = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_SRA  = 6'h03;
  localparam logic [FUNCT_W-1:0] FN_JR   = 6'h08;
  localparam logic [FUNCT_W-1:0] FN_JALR = 6'h09;
  localparam logic [FUNCT_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FUNCT_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FUNCT_W-1:0] FN_AND  = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR   = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR  = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_NOR  = 6'h27;
  localparam logic [FUNCT_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [FUNCT_W-1:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic [FUNCT_W-1:0] funct;
    logic [SHAMT_W-1:0] shamt;
    logic               illegal;
  } id_ctrl_t;

  function automatic logic [OP_W-1:0] seg_op(input logic [INST_W-1:0] inst);
    return inst[POS_OP +: OP_W];
  endfunction

  function automatic logic [SEG_REG_W-1:0] seg_rs(input logic [INST_W-1:0] inst);
    return inst[POS_RS +: SEG_REG_W];
  endfunction

  function automatic logic [SEG_REG_W-1:0] seg_rt(input logic [INST_W-1:0] inst);
    return inst[POS_RT +: SEG_REG_W];
  endfunction

  function automatic logic [SEG_REG_W-1:0] seg_rd(input logic [INST_W-1:0] inst);
    return inst[POS_RD +: SEG_REG_W];
  endfunction

  function automatic logic [SHAMT_W-1:0] seg_shamt(input logic [INST_W-1:0] inst);
    return inst[POS_SHAMT +: SHAMT_W];
  endfunction

  function automatic logic [FUNCT_W-1:0] seg_funct(input logic [INST_W-1:0] inst);
    return inst[POS_FUNCT +: FUNCT_W];
  endfunction

  function automatic logic [IMM_W-1:0] seg_imm(input logic [INST_W-1:0] inst);
    return inst[POS_IMM +: IMM_W];
  endfunction

  // Maps every opcode onto the ALU FUNCT that EX should apply; link ops add a zero operand.
  function automatic logic [FUNCT_W-1:0] funct_gen(input logic [OP_W-1:0]      op,
                                                   input logic [SEG_REG_W-1:0] rt,
                                                   input logic [FUNCT_W-1:0]   fn);
    logic [FUNCT_W-1:0] f;
    f = FN_SLL;
    case (op)
      OP_SPECIAL: f = fn;
      OP_ADDI:    f = FN_ADD;
      OP_ADDIU:   f = FN_ADDU;
      OP_SLTI:    f = FN_SLT;
      OP_SLTIU:   f = FN_SLTU;
      OP_ANDI:    f = FN_AND;
      OP_ORI:     f = FN_OR;
      OP_XORI:    f = FN_XOR;
      OP_LUI:     f = FN_OR;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW, OP_JAL: f = FN_ADDU;
      OP_REGIMM:  if (rt == RI_BLTZAL || rt == RI_BGEZAL) f = FN_ADDU;
      default:    f = FN_SLL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational MIPS decode: read ports, operands, write-back target, FUNCT, illegal.
// With ID_BYPASS_EN defined, a same-cycle write-back port overrides regfile read data.
module id_decode_comb
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LINK_OFS = 8
) (
  input  logic [INST_W-1:0] inst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] reg_data_1,
  input  logic [DATA_W-1:0] reg_data_2,
`ifdef ID_BYPASS_EN
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
`endif
  output logic              read_en_1,
  output logic              read_en_2,
  output logic [REG_AW-1:0] read_addr_1,
  output logic [REG_AW-1:0] read_addr_2,
  output logic [DATA_W-1:0] operand_1,
  output logic [DATA_W-1:0] operand_2,
  output logic [DATA_W-1:0] store_data,
  output logic              write_en,
  output logic [REG_AW-1:0] write_addr,
  output id_ctrl_t          ctrl
);

  logic [OP_W-1:0]      op;
  logic [SEG_REG_W-1:0] rs, rt, rd;
  logic [FUNCT_W-1:0]   fn;
  logic [IMM_W-1:0]     imm;

  assign op  = seg_op(inst);
  assign rs  = seg_rs(inst);
  assign rt  = seg_rt(inst);
  assign rd  = seg_rd(inst);
  assign fn  = seg_funct(inst);
  assign imm = seg_imm(inst);

  logic is_special, is_imm_s, is_imm_z, is_lui, is_load, is_store;
  logic is_br2, is_br1, is_regimm, regimm_ok, regimm_link, is_cp0, is_j, is_jal;
  logic known_op, is_jr, is_jalr;

  // Instruction class flags
  always_comb begin
    is_special  = 1'b0;
    is_imm_s    = 1'b0;
    is_imm_z    = 1'b0;
    is_lui      = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_br2      = 1'b0;
    is_br1      = 1'b0;
    is_regimm   = 1'b0;
    is_cp0      = 1'b0;
    is_j        = 1'b0;
    is_jal      = 1'b0;
    regimm_ok   = 1'b0;
    regimm_link = 1'b0;
    case (op)
      OP_SPECIAL:                             is_special = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU:   is_imm_s   = 1'b1;
      OP_ANDI, OP_ORI, OP_XORI:               is_imm_z   = 1'b1;
      OP_LUI:                                 is_lui     = 1'b1;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:    is_load    = 1'b1;
      OP_SB, OP_SH, OP_SW:                    is_store   = 1'b1;
      OP_BEQ, OP_BNE:                         is_br2     = 1'b1;
      OP_BLEZ, OP_BGTZ:                       is_br1     = 1'b1;
      OP_REGIMM:                              is_regimm  = 1'b1;
      OP_CP0:                                 is_cp0     = 1'b1;
      OP_J:                                   is_j       = 1'b1;
      OP_JAL:                                 is_jal     = 1'b1;
      default: ;
    endcase
    case (rt)
      RI_BLTZ, RI_BGEZ:     regimm_ok = is_regimm;
      RI_BLTZAL, RI_BGEZAL: begin
        regimm_ok   = is_regimm;
        regimm_link = is_regimm;
      end
      default: ;
    endcase
  end

  assign known_op = is_special | is_imm_s | is_imm_z | is_lui | is_load | is_store |
                    is_br2 | is_br1 | is_regimm | is_cp0 | is_j | is_jal;
  assign is_jr    = is_special & (fn == FN_JR);
  assign is_jalr  = is_special & (fn == FN_JALR);

  assign read_en_1   = is_special | is_imm_s | is_imm_z | is_load | is_store |
                       is_br2 | is_br1 | regimm_ok;
  assign read_en_2   = is_special | is_store | is_br2 | (is_cp0 & (rs == CP0_MT));
  assign read_addr_1 = read_en_1 ? REG_AW'(rs) : '0;
  assign read_addr_2 = read_en_2 ? REG_AW'(rt) : '0;

  logic [DATA_W-1:0] data_1, data_2;

`ifdef ID_BYPASS_EN
  // $0 never bypasses: it is hard-wired zero regardless of write-back traffic.
  assign data_1 = (wb_en && read_en_1 && read_addr_1 != '0 && read_addr_1 == wb_addr) ?
                  wb_data : reg_data_1;
  assign data_2 = (wb_en && read_en_2 && read_addr_2 != '0 && read_addr_2 == wb_addr) ?
                  wb_data : reg_data_2;
`else
  assign data_1 = reg_data_1;
  assign data_2 = reg_data_2;
`endif

  logic [DATA_W-1:0] link, imm_sext, imm_zext, imm_lui;

  assign link     = DATA_W'(addr + ADDR_W'(LINK_OFS));
  assign imm_sext = DATA_W'($signed(imm));
  assign imm_zext = DATA_W'(imm);
  assign imm_lui  = DATA_W'(imm) << IMM_W;

  always_comb begin
    operand_1 = '0;
    if (is_jal || is_jalr || regimm_link)
      operand_1 = link;
    else if (is_special || is_imm_s || is_imm_z || is_load || is_store)
      operand_1 = data_1;
  end

  always_comb begin
    operand_2 = '0;
    if (is_imm_z)                             operand_2 = imm_zext;
    else if (is_lui)                          operand_2 = imm_lui;
    else if (is_imm_s || is_load || is_store) operand_2 = imm_sext;
    else if (is_special)                      operand_2 = data_2;
  end

  assign store_data = is_store ? data_2 : '0;

  // Write-back target; a $0 target is reported with the enable cleared.
  always_comb begin
    write_addr = '0;
    if (is_special && !is_jr)                write_addr = REG_AW'(rd);
    else if (is_imm_s || is_imm_z || is_lui || is_load) write_addr = REG_AW'(rt);
    else if (is_jal || regimm_link)          write_addr = REG_AW'(LINK_REG);
  end

  assign write_en = (write_addr != '0);

  assign ctrl.funct   = funct_gen(op, rt, fn);
  assign ctrl.shamt   = is_special ? seg_shamt(inst) : '0;
  assign ctrl.illegal = !known_op | (is_regimm & !regimm_ok);

endmodule

// File: rtl/id_stage_pipe.sv
// Registered MIPS decode stage with valid/ready handshake, load-use stall and flush.
// Define ID_BYPASS_EN to add the wb_en/wb_addr/wb_data same-cycle bypass ports.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LINK_OFS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [INST_W-1:0]  in_inst,
  output logic               reg_read_en_1,
  output logic               reg_read_en_2,
  output logic [REG_AW-1:0]  reg_addr_1,
  output logic [REG_AW-1:0]  reg_addr_2,
  input  logic [DATA_W-1:0]  reg_data_1,
  input  logic [DATA_W-1:0]  reg_data_2,
`ifdef ID_BYPASS_EN
  input  logic               wb_en,
  input  logic [REG_AW-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
`endif
  input  logic               ex_load,
  input  logic [REG_AW-1:0]  ex_dst,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_write_reg_en,
  output logic [REG_AW-1:0]  out_write_reg_addr,
  output logic [FUNCT_W-1:0] out_funct,
  output logic [SHAMT_W-1:0] out_shamt,
  output logic [DATA_W-1:0]  out_operand_1,
  output logic [DATA_W-1:0]  out_operand_2,
  output logic [DATA_W-1:0]  out_store_data,
  output logic               out_illegal
);

  logic              dec_re_1, dec_re_2, dec_wen;
  logic [REG_AW-1:0] dec_ra_1, dec_ra_2, dec_waddr;
  logic [DATA_W-1:0] dec_op_1, dec_op_2, dec_sd;
  id_ctrl_t          dec_ctrl;

  id_decode_comb #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .REG_AW   (REG_AW),
    .LINK_OFS (LINK_OFS)
  ) u_decode (
    .inst        (in_inst),
    .addr        (in_addr),
    .reg_data_1  (reg_data_1),
    .reg_data_2  (reg_data_2),
`ifdef ID_BYPASS_EN
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
`endif
    .read_en_1   (dec_re_1),
    .read_en_2   (dec_re_2),
    .read_addr_1 (dec_ra_1),
    .read_addr_2 (dec_ra_2),
    .operand_1   (dec_op_1),
    .operand_2   (dec_op_2),
    .store_data  (dec_sd),
    .write_en    (dec_wen),
    .write_addr  (dec_waddr),
    .ctrl        (dec_ctrl)
  );

  // Read ports are quiet while reset is held.
  assign reg_read_en_1 = rst & dec_re_1;
  assign reg_read_en_2 = rst & dec_re_2;
  assign reg_addr_1    = rst ? dec_ra_1 : '0;
  assign reg_addr_2    = rst ? dec_ra_2 : '0;

  logic stall_c, transfer_c;

  assign stall_c = in_valid & ex_load & (ex_dst != '0) &
                   ((reg_read_en_1 & (reg_addr_1 == ex_dst)) |
                    (reg_read_en_2 & (reg_addr_2 == ex_dst)));

  assign in_ready   = flush | (!stall_c & (!out_valid | out_ready));
  assign transfer_c = in_valid & in_ready & !flush;

  // Output register: reset, then flush, then accept, then drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid          <= 1'b0;
      out_write_reg_en   <= 1'b0;
      out_write_reg_addr <= '0;
      out_funct          <= '0;
      out_shamt          <= '0;
      out_operand_1      <= '0;
      out_operand_2      <= '0;
      out_store_data     <= '0;
      out_illegal        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (transfer_c) begin
      out_valid          <= 1'b1;
      out_write_reg_en   <= dec_wen;
      out_write_reg_addr <= dec_waddr;
      out_funct          <= dec_ctrl.funct;
      out_shamt          <= dec_ctrl.shamt;
      out_operand_1      <= dec_op_1;
      out_operand_2      <= dec_op_2;
      out_store_data     <= dec_sd;
      out_illegal        <= dec_ctrl.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed vector table, hand sequences, random vs. model.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_addr, in_inst;
  logic        reg_read_en_1, reg_read_en_2;
  logic [4:0]  reg_addr_1, reg_addr_2;
  logic [31:0] reg_data_1, reg_data_2;
  logic        ex_load;
  logic [4:0]  ex_dst;
  logic        out_valid, out_ready, out_write_reg_en, out_illegal;
  logic [4:0]  out_write_reg_addr, out_shamt;
  logic [5:0]  out_funct;
  logic [31:0] out_operand_1, out_operand_2, out_store_data;
`ifdef ID_BYPASS_EN
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
`endif

  logic [31:0] rf [32];
  assign reg_data_1 = rf[reg_addr_1];
  assign reg_data_2 = rf[reg_addr_2];

  always #5 clk = ~clk;

  id_stage_pipe dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_addr            (in_addr),
    .in_inst            (in_inst),
    .reg_read_en_1      (reg_read_en_1),
    .reg_read_en_2      (reg_read_en_2),
    .reg_addr_1         (reg_addr_1),
    .reg_addr_2         (reg_addr_2),
    .reg_data_1         (reg_data_1),
    .reg_data_2         (reg_data_2),
`ifdef ID_BYPASS_EN
    .wb_en              (wb_en),
    .wb_addr            (wb_addr),
    .wb_data            (wb_data),
`endif
    .ex_load            (ex_load),
    .ex_dst             (ex_dst),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_write_reg_en   (out_write_reg_en),
    .out_write_reg_addr (out_write_reg_addr),
    .out_funct          (out_funct),
    .out_shamt          (out_shamt),
    .out_operand_1      (out_operand_1),
    .out_operand_2      (out_operand_2),
    .out_store_data     (out_store_data),
    .out_illegal        (out_illegal)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        re1, re2;
    logic [4:0]  ra1, ra2;
    logic [31:0] op1, op2, sd;
    logic        wen;
    logic [4:0]  waddr;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic        ill;
  } exp_t;

  // Behavioural reference: operand sources and targets from the ISA rules, plain arithmetic.
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] addr);
    exp_t e;
    int op, rs, rt, rd, sh, fn, imm, sext, dst;
    bit use_rs, use_rt, has_dst;
    op = int'(inst[31:26]); rs = int'(inst[25:21]); rt = int'(inst[20:16]);
    rd = int'(inst[15:11]); sh = int'(inst[10:6]);  fn = int'(inst[5:0]);
    imm = int'(inst[15:0]);
    sext = (imm >= 32768) ? imm - 65536 : imm;
    use_rs = 0; use_rt = 0; has_dst = 0; dst = 0;
    e.op1 = 0; e.op2 = 0; e.sd = 0; e.fn = 0; e.sh = 0; e.ill = 0;
    case (op)
      0: begin
        use_rs = 1; use_rt = 1;
        e.op1 = (fn == 9) ? addr + 8 : rf[rs];
        e.op2 = rf[rt]; e.fn = 6'(fn); e.sh = 5'(sh);
        if (fn != 8) begin has_dst = 1; dst = rd; end
      end
      8, 9, 10, 11: begin
        use_rs = 1; e.op1 = rf[rs]; e.op2 = 32'(sext); has_dst = 1; dst = rt;
        e.fn = (op == 8) ? 6'h20 : (op == 9) ? 6'h21 : (op == 10) ? 6'h2A : 6'h2B;
      end
      12, 13, 14: begin
        use_rs = 1; e.op1 = rf[rs]; e.op2 = 32'(imm); has_dst = 1; dst = rt;
        e.fn = (op == 12) ? 6'h24 : (op == 13) ? 6'h25 : 6'h26;
      end
      15: begin e.op2 = 32'(imm * 65536); has_dst = 1; dst = rt; e.fn = 6'h25; end
      32, 33, 35, 36, 37: begin
        use_rs = 1; e.op1 = rf[rs]; e.op2 = 32'(sext); has_dst = 1; dst = rt; e.fn = 6'h21;
      end
      40, 41, 43: begin
        use_rs = 1; use_rt = 1; e.op1 = rf[rs]; e.op2 = 32'(sext); e.sd = rf[rt]; e.fn = 6'h21;
      end
      4, 5: begin use_rs = 1; use_rt = 1; end
      6, 7: use_rs = 1;
      1: begin
        if (rt == 0 || rt == 1) use_rs = 1;
        else if (rt == 16 || rt == 17) begin
          use_rs = 1; e.op1 = addr + 8; has_dst = 1; dst = 31; e.fn = 6'h21;
        end else e.ill = 1;
      end
      16: use_rt = (rs == 4);
      2: ;
      3: begin e.op1 = addr + 8; has_dst = 1; dst = 31; e.fn = 6'h21; end
      default: e.ill = 1;
    endcase
    e.re1 = use_rs; e.ra1 = use_rs ? 5'(rs) : 5'd0;
    e.re2 = use_rt; e.ra2 = use_rt ? 5'(rt) : 5'd0;
    e.waddr = has_dst ? 5'(dst) : 5'd0;
    e.wen = has_dst && dst != 0;
    return e;
  endfunction

  typedef struct {
    logic [31:0] inst, addr, op1, op2, sd;
    logic [4:0]  waddr;
    logic        wen, re1, re2, ill;
    logic [5:0]  fn;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [31:0] rand_inst();
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] imm;
    int k;
    k = $urandom_range(0, 25);
    case (k)
      0: op = 6'h00;  1: op = 6'h01;  2: op = 6'h02;  3: op = 6'h03;
      4: op = 6'h04;  5: op = 6'h06;  6: op = 6'h08;  7: op = 6'h09;
      8: op = 6'h0A;  9: op = 6'h0B; 10: op = 6'h0C; 11: op = 6'h0D;
     12: op = 6'h0E; 13: op = 6'h0F; 14: op = 6'h10; 15: op = 6'h20;
     16: op = 6'h23; 17: op = 6'h25; 18: op = 6'h28; 19: op = 6'h2B;
     20: op = 6'h3F; 21: op = 6'h11; 22: op = 6'h29; 23: op = 6'h24;
     default: op = 6'h00;
    endcase
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7)); sh = 5'($urandom_range(0, 31));
    k = $urandom_range(0, 5);
    fn = (k == 0) ? 6'h08 : (k == 1) ? 6'h09 : (k == 2) ? 6'h00 : (k == 3) ? 6'h2A : 6'($urandom_range(32, 39));
    if (op == 6'h01) begin
      k = $urandom_range(0, 4);
      rt = (k == 0) ? 5'h00 : (k == 1) ? 5'h01 : (k == 2) ? 5'h10 : (k == 3) ? 5'h11 : 5'h05;
    end
    if (op == 6'h10) rs = ($urandom_range(0, 1) == 1) ? 5'h04 : 5'h00;
    imm = {rd, sh, fn};
    if (op != 6'h00) imm = 16'($urandom);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    exp_t e, m_b;
    bit   m_valid, stall, rdy;

    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i);
    rf[0] = 32'h0; rf[1] = 32'h0000_00F0; rf[2] = 32'h1234_5678;
    rf[5] = 32'h0000_0055; rf[7] = 32'h0000_0077;

    vecs[0]  = '{32'h3422_8001, 32'h0000_0000, 32'h0000_00F0, 32'h0000_8001, 32'h0, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 6'h25};
    vecs[1]  = '{32'h2023_FFFC, 32'h0000_0004, 32'h0000_00F0, 32'hFFFF_FFFC, 32'h0, 5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 6'h20};
    vecs[2]  = '{32'h3C04_1234, 32'h0000_0008, 32'h0,         32'h1234_0000, 32'h0, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 6'h25};
    vecs[3]  = '{32'h0C00_0100, 32'h0000_0400, 32'h0000_0408, 32'h0,         32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 6'h21};
    vecs[4]  = '{32'h0022_0020, 32'h0000_0404, 32'h0000_00F0, 32'h1234_5678, 32'h0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 6'h20};
    vecs[5]  = '{32'hFC22_1234, 32'h0000_0408, 32'h0,         32'h0,         32'h0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 6'h00};
    vecs[6]  = '{32'hACA7_0008, 32'h0000_040C, 32'h0000_0055, 32'h0000_0008, 32'h77, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h21};
    vecs[7]  = '{32'h04B1_0010, 32'h0000_1000, 32'h0000_1008, 32'h0,         32'h0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 6'h21};
    vecs[8]  = '{32'h04A5_0010, 32'h0000_1004, 32'h0,         32'h0,         32'h0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 6'h00};
    vecs[9]  = '{32'h8C29_FFF0, 32'h0000_1008, 32'h0000_00F0, 32'hFFFF_FFF0, 32'h0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 6'h21};
    vecs[10] = '{32'h0020_0008, 32'h0000_100C, 32'h0000_00F0, 32'h0,         32'h0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 6'h08};
    vecs[11] = '{32'h3848_FFFF, 32'h0000_1010, 32'h1234_5678, 32'h0000_FFFF, 32'h0, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 6'h26};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_addr = 32'h0; in_inst = 32'h3422_8001;
    ex_load = 1'b0; ex_dst = 5'd0; out_ready = 1'b1;
`ifdef ID_BYPASS_EN
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_op1", out_operand_1, 32'h0);
    chk("rst_read_en_1", 32'(reg_read_en_1), 32'h0);
    chk("rst_read_addr_1", 32'(reg_addr_1), 32'h0);

    @(negedge clk);
    rst = 1'b1;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      in_inst = vecs[i].inst; in_addr = vecs[i].addr; in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'h1);
      chk($sformatf("v%0d_re1", i), 32'(reg_read_en_1), 32'(vecs[i].re1));
      chk($sformatf("v%0d_re2", i), 32'(reg_read_en_2), 32'(vecs[i].re2));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("v%0d_op1", i), out_operand_1, vecs[i].op1);
      chk($sformatf("v%0d_op2", i), out_operand_2, vecs[i].op2);
      chk($sformatf("v%0d_sd", i), out_store_data, vecs[i].sd);
      chk($sformatf("v%0d_waddr", i), 32'(out_write_reg_addr), 32'(vecs[i].waddr));
      chk($sformatf("v%0d_wen", i), 32'(out_write_reg_en), 32'(vecs[i].wen));
      chk($sformatf("v%0d_ill", i), 32'(out_illegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d_funct", i), 32'(out_funct), 32'(vecs[i].fn));
      @(negedge clk);
    end

    // Load-use stall produces bubbles, then the instruction goes through
    ex_load = 1'b1; ex_dst = 5'd5; in_inst = 32'h00A7_3020; in_addr = 32'h2000;
    for (int c = 0; c < 3; c++) begin
      #1 chk("stall_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("stall_bubble", 32'(out_valid), 32'h0);
      @(negedge clk);
    end
    ex_dst = 5'd7;
    #1 chk("stall_rt_in_ready", 32'(in_ready), 32'h0);
    ex_load = 1'b0;
    #1 chk("unstall_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("unstall_valid", 32'(out_valid), 32'h1);
    chk("unstall_op1", out_operand_1, 32'h55);
    chk("unstall_op2", out_operand_2, 32'h77);
    chk("unstall_waddr", 32'(out_write_reg_addr), 32'd6);

    // ex_dst == 0 never stalls
    @(negedge clk);
    ex_load = 1'b1; ex_dst = 5'd0; in_inst = 32'h0007_3020;
    #1 chk("dst0_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("dst0_valid", 32'(out_valid), 32'h1);
    chk("dst0_op1", out_operand_1, 32'h0);

    // Backpressure holds the bundle, then flush clears it
    @(negedge clk);
    ex_load = 1'b0; out_ready = 1'b0; in_inst = 32'h3422_8001;
    for (int c = 0; c < 3; c++) begin
      #1 chk("hold_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_op2", out_operand_2, 32'h77);
      chk("hold_waddr", 32'(out_write_reg_addr), 32'd6);
      @(negedge clk);
    end
    flush = 1'b1;
    #1 chk("flush_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("flush_valid", 32'(out_valid), 32'h0);

    // Flush beats a simultaneous stall
    @(negedge clk);
    out_ready = 1'b1; ex_load = 1'b1; ex_dst = 5'd5; in_inst = 32'h00A7_3020;
    #1 chk("flush_stall_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    chk("flush_stall_valid", 32'(out_valid), 32'h0);

    // Reset during a stall with a held bundle
    @(negedge clk);
    flush = 1'b0; ex_load = 1'b0; in_inst = 32'h3422_8001;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    ex_load = 1'b1; in_inst = 32'h00A7_3020; out_ready = 1'b0; rst = 1'b0;
    #1 chk("rst_stall_re1", 32'(reg_read_en_1), 32'h0);
    @(posedge clk); #1;
    chk("rst_stall_valid", 32'(out_valid), 32'h0);
    chk("rst_stall_op1", out_operand_1, 32'h0);
    chk("rst_stall_wen", 32'(out_write_reg_en), 32'h0);
    @(negedge clk);
    rst = 1'b1; ex_load = 1'b0; out_ready = 1'b1;

`ifdef ID_BYPASS_EN
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEAD_BEEF; in_inst = 32'h0020_1021;
    @(posedge clk); #1;
    chk("byp_op1", out_operand_1, 32'hDEAD_BEEF);
    @(negedge clk);
    wb_addr = 5'd0;
    @(posedge clk); #1;
    chk("byp0_op1", out_operand_1, 32'h0000_00F0);
    chk("byp0_op2", out_operand_2, 32'h0);
    @(negedge clk);
    wb_en = 1'b0;
`endif

    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_valid = 1'b0;
    m_b = model(32'h0, 32'h0);

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) rf[$urandom_range(1, 7)] = $urandom;
      in_inst   = rand_inst();
      in_addr   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ex_load   = ($urandom_range(0, 1) == 1);
      ex_dst    = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      e = model(in_inst, in_addr);
      stall = in_valid && ex_load && ex_dst != 0 &&
              ((e.re1 && e.ra1 == ex_dst) || (e.re2 && e.ra2 == ex_dst));
      rdy = flush || (!stall && (!m_valid || out_ready));
      chk("rnd_in_ready", 32'(in_ready), 32'(rdy));
      chk("rnd_re1", {26'(reg_read_en_1), reg_addr_1}, {26'(e.re1), e.ra1});
      chk("rnd_re2", {26'(reg_read_en_2), reg_addr_2}, {26'(e.re2), e.ra2});
      @(posedge clk);
      if (flush) m_valid = 1'b0;
      else if (in_valid && rdy) begin m_valid = 1'b1; m_b = e; end
      else if (out_ready) m_valid = 1'b0;
      #1;
      chk("rnd_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_op1", out_operand_1, m_b.op1);
        chk("rnd_op2", out_operand_2, m_b.op2);
        chk("rnd_sd", out_store_data, m_b.sd);
        chk("rnd_wb", {26'(out_write_reg_en), out_write_reg_addr}, {26'(m_b.wen), m_b.waddr});
        chk("rnd_funct", {21'(out_illegal), out_shamt, out_funct}, {21'(m_b.ill), m_b.sh, m_b.fn});
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
